// File: rtl/cpu_divide_pkg.sv
// Shared CPU definitions: divider state encoding, RV32M divide funct3 codes
// and ALU op codes.
package cpu_divide_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2
    } div_state_t;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    function automatic logic funct3_is_signed(input logic [2:0] funct3);
        return (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
    endfunction

    function automatic logic funct3_wants_rem(input logic [2:0] funct3);
        return (funct3 == FUNCT3_REM) || (funct3 == FUNCT3_REMU);
    endfunction

endpackage

// File: rtl/cpu_divide_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor and subtract when it fits.
module cpu_divide_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // After a successful subtract the result is below den, so it fits WIDTH bits.
    always_comb begin
        q_bit    = (rem >= {1'b0, den});
        rem_next = q_bit ? WIDTH'(rem - {1'b0, den}) : rem[WIDTH-1:0];
    end

endmodule

// File: rtl/cpu_divide.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one quotient bit per clock,
// divide-by-zero and signed overflow resolved in the request cycle.
module cpu_divide
    import cpu_divide_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_request,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_numerator,
    input  logic [WIDTH-1:0] i_denominator,
    output logic             o_busy,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic [WIDTH-1:0] rem;
    logic             sign_q;
    logic             sign_r;

    logic             num_neg;
    logic             den_neg;
    logic [WIDTH-1:0] num_abs;
    logic [WIDTH-1:0] den_abs;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    always_comb begin
        num_neg   = i_signed & i_numerator[WIDTH-1];
        den_neg   = i_signed & i_denominator[WIDTH-1];
        num_abs   = num_neg ? -i_numerator : i_numerator;
        den_abs   = den_neg ? -i_denominator : i_denominator;
        div_zero  = (i_denominator == '0);
        overflow  = i_signed && (i_numerator == MOST_NEG) && (i_denominator == '1);
        // num doubles as the dividend shift-out and the quotient shift-in.
        rem_shift = {rem, num[WIDTH-1]};
    end

    cpu_divide_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_shift),
        .den     (den),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_request && !div_zero && !overflow) state_next = ITER;
            ITER:    if (count == '0) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count       <= '0;
            num         <= '0;
            den         <= '0;
            rem         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            o_ready     <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            o_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_request) begin
                        if (div_zero) begin
                            o_quotient  <= '1;
                            o_remainder <= i_numerator;
                            o_ready     <= 1'b1;
                        end else if (overflow) begin
                            o_quotient  <= i_numerator;
                            o_remainder <= '0;
                            o_ready     <= 1'b1;
                        end else begin
                            num    <= num_abs;
                            den    <= den_abs;
                            rem    <= '0;
                            count  <= CNT_W'(WIDTH - 1);
                            sign_q <= num_neg ^ den_neg;
                            sign_r <= num_neg;
                        end
                    end
                end
                ITER: begin
                    rem   <= rem_next;
                    num   <= {num[WIDTH-2:0], q_bit};
                    count <= count - 1'b1;
                end
                FIXUP: begin
                    o_quotient  <= sign_q ? -num : num;
                    o_remainder <= sign_r ? -rem : rem;
                    o_ready     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_cpu_divide.sv
// Bench for cpu_divide: arithmetic reference model with per-cycle output
// checking plus directed scenarios with literal expectations.
module tb_cpu_divide;

    logic        i_clock;
    logic        i_reset;
    logic        i_request;
    logic        i_signed;
    logic [31:0] i_numerator;
    logic [31:0] i_denominator;
    logic        o_busy;
    logic        o_ready;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    cpu_divide #(
        .WIDTH(32)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_request    (i_request),
        .i_signed     (i_signed),
        .i_numerator  (i_numerator),
        .i_denominator(i_denominator),
        .o_busy       (o_busy),
        .o_ready      (o_ready),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          due;
        bit          special;
    } exp_t;

    exp_t        q_exp[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // RISC-V division semantics expressed with plain arithmetic.
    function automatic void ref_div(input bit s, input logic [31:0] n, input logic [31:0] d,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output bit special);
        special = 1'b0;
        if (d == 32'd0) begin
            q = 32'hFFFF_FFFF; r = n; special = 1'b1;
        end else if (s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = n; r = 32'd0; special = 1'b1;
        end else if (s) begin
            q = $signed(n) / $signed(d);
            r = $signed(n) % $signed(d);
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    // Acceptance model: a request is taken whenever no result is outstanding.
    always @(posedge i_clock) begin
        exp_t e;
        cyc++;
        if (!i_reset && i_request && q_exp.size() == 0) begin
            ref_div(i_signed, i_numerator, i_denominator, e.q, e.r, e.special);
            e.due = e.special ? cyc : cyc + 33;
            q_exp.push_back(e);
        end
    end

    always @(negedge i_clock) begin
        bit ready_exp;
        bit busy_exp;
        if (i_reset) begin
            last_q = '0;
            last_r = '0;
            check($sformatf("rst_ready@%0d", cyc), {31'd0, o_ready}, 32'd0);
            check($sformatf("rst_busy@%0d", cyc), {31'd0, o_busy}, 32'd0);
            check($sformatf("rst_quot@%0d", cyc), o_quotient, 32'd0);
            check($sformatf("rst_rem@%0d", cyc), o_remainder, 32'd0);
        end else begin
            ready_exp = (q_exp.size() != 0) && (q_exp[0].due == cyc);
            busy_exp  = (q_exp.size() != 0) && !q_exp[0].special && (cyc < q_exp[0].due);
            check($sformatf("ready@%0d", cyc), {31'd0, o_ready}, {31'd0, ready_exp});
            check($sformatf("busy@%0d", cyc), {31'd0, o_busy}, {31'd0, busy_exp});
            if (ready_exp) begin
                last_q = q_exp[0].q;
                last_r = q_exp[0].r;
                void'(q_exp.pop_front());
            end
            check($sformatf("quot@%0d", cyc), o_quotient, last_q);
            check($sformatf("rem@%0d", cyc), o_remainder, last_r);
        end
    end

    // Drive a request from the current time; returns the acceptance edge count.
    task automatic issue(input bit s, input logic [31:0] n, input logic [31:0] d, output int e0);
        i_request     = 1'b1;
        i_signed      = s;
        i_numerator   = n;
        i_denominator = d;
        @(posedge i_clock);
        #1;
        e0            = cyc;
        i_request     = 1'b0;
        i_signed      = $urandom_range(0, 1) != 0;
        i_numerator   = $urandom;
        i_denominator = $urandom;
    endtask

    // Latency is measured in edges after the acceptance edge (0 = same edge).
    task automatic wait_ready(input string name, input int e0, input logic [31:0] eq,
                              input logic [31:0] er, input int lat, input int busy_exp);
        bit seen = 1'b0;
        int busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clock);
            if (o_ready) begin
                seen = 1'b1;
                break;
            end
            if (o_busy) busy_n++;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout actual=no_ready required=ready", name);
        end else begin
            check({name, "_lat"}, 32'(cyc - e0), 32'(lat));
            check({name, "_q"}, o_quotient, eq);
            check({name, "_r"}, o_remainder, er);
            if (busy_exp >= 0) check({name, "_busycnt"}, 32'(busy_n), 32'(busy_exp));
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clock);
            #1;
            if (q_exp.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout actual=pending required=idle", name);
        end
    endtask

    initial begin
        int          e0;
        logic [31:0] mq;
        logic [31:0] mr;
        bit          msp;

        ref_div(1'b0, 32'd100, 32'd7, mq, mr, msp);
        check("model_100_7_q", mq, 32'd14);
        check("model_100_7_r", mr, 32'd2);
        ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, mq, mr, msp);
        check("model_m7_2_q", mq, 32'hFFFF_FFFD);
        check("model_m7_2_r", mr, 32'hFFFF_FFFF);
        ref_div(1'b1, 32'd7, 32'hFFFF_FFFE, mq, mr, msp);
        check("model_7_m2_q", mq, 32'hFFFF_FFFD);
        check("model_7_m2_r", mr, 32'd1);
        ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mq, mr, msp);
        check("model_ovf_q", mq, 32'h8000_0000);
        check("model_ovf_r", mr, 32'd0);

        i_reset       = 1'b1;
        i_request     = 1'b0;
        i_signed      = 1'b0;
        i_numerator   = '0;
        i_denominator = '0;
        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b0;
        @(negedge i_clock);

        issue(1'b0, 32'd100, 32'd7, e0);
        wait_ready("u100_7", e0, 32'd14, 32'd2, 33, 33);

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, e0);
        wait_ready("s_m7_2", e0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 33);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, e0);
        wait_ready("s_7_m2", e0, 32'hFFFF_FFFD, 32'd1, 33, 33);

        issue(1'b0, 32'd5, 32'd0, e0);
        wait_ready("u_div0", e0, 32'hFFFF_FFFF, 32'd5, 0, 0);
        issue(1'b1, 32'd5, 32'd0, e0);
        wait_ready("s_div0", e0, 32'hFFFF_FFFF, 32'd5, 0, 0);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e0);
        wait_ready("s_ovf", e0, 32'h8000_0000, 32'd0, 0, 0);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, e0);
        wait_ready("u_ovfops", e0, 32'd0, 32'h8000_0000, 33, 33);

        // Stray request during iteration must not disturb the running division.
        issue(1'b0, 32'd1000, 32'd10, e0);
        repeat (5) @(posedge i_clock);
        #1;
        i_request = 1'b1; i_signed = 1'b1; i_numerator = 32'd77; i_denominator = 32'd3;
        @(posedge i_clock);
        #1 i_request = 1'b0;
        wait_ready("midreq", e0, 32'd100, 32'd0, 33, -1);

        // Back-to-back: the next request is raised in the o_ready cycle.
        issue(1'b0, 32'd100, 32'd7, e0);
        wait_ready("b2b_first", e0, 32'd14, 32'd2, 33, 33);
        issue(1'b0, 32'd50, 32'd5, e0);
        wait_ready("b2b_second", e0, 32'd10, 32'd0, 33, 33);

        issue(1'b0, 32'd200, 32'd3, e0);
        repeat (10) @(posedge i_clock);
        #2;
        q_exp.delete();
        i_reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_ready", {31'd0, o_ready}, 32'd0);
        check("abort_q", o_quotient, 32'd0);
        check("abort_r", o_remainder, 32'd0);
        repeat (2) @(posedge i_clock);
        #1 i_reset = 1'b0;
        @(negedge i_clock);
        issue(1'b0, 32'd9, 32'd3, e0);
        wait_ready("after_rst", e0, 32'd3, 32'd0, 33, 33);

        for (int i = 0; i < 8; i++) begin
            bit          s;
            logic [31:0] n;
            logic [31:0] d;
            s = $urandom_range(0, 1) != 0;
            n = $urandom;
            d = (i < 4) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 2) d = 32'hFFFF_FFFF;
            if (i == 5) n = 32'h8000_0000;
            issue(s, n, d, e0);
            wait_idle($sformatf("rand%0d", i));
        end

        repeat (2) @(negedge i_clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
